// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, ALUOp codes
// (same encoding as the single-cycle decoder), state encodings and mux selects.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [3:0] ALUOP_R    = 4'b1111;
  localparam logic [3:0] ALUOP_ADD  = 4'b0001;
  localparam logic [3:0] ALUOP_ORI  = 4'b0010;
  localparam logic [3:0] ALUOP_ANDI = 4'b0011;
  localparam logic [3:0] ALUOP_LUI  = 4'b0100;
  localparam logic [3:0] ALUOP_SW   = 4'b0101;
  localparam logic [3:0] ALUOP_LW   = 4'b0110;
  localparam logic [3:0] ALUOP_BEQ  = 4'b0111;
  localparam logic [3:0] ALUOP_BNE  = 4'b1000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation for the immediate-format arithmetic/logic instructions.
  function automatic logic [3:0] imm_alu_op(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI: return ALUOP_ANDI;
      OP_ORI:  return ALUOP_ORI;
      OP_LUI:  return ALUOP_LUI;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the controller (master) and the multicycle datapath (slave):
// opcode and memory handshake in, datapath control strobes and status out.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [5:0]                 op;
  logic                       mem_ready;
  logic                       PCWrite;
  logic                       BranchEQ;
  logic                       BranchNE;
  logic                       IorD;
  logic                       MemRead;
  logic                       MemWrite;
  logic                       IRWrite;
  logic                       MemtoReg;
  logic                       RegDst;
  logic                       RegWrite;
  logic                       ALUSrcA;
  logic [1:0]                 ALUSrcB;
  logic [1:0]                 PCSource;
  logic [3:0]                 ALUOp;
  logic [$bits(state_t)-1:0]  state_o;
  logic                       illegal_op;
  logic                       mem_timeout;

  modport master (
    input  op, mem_ready,
    output PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state_o, illegal_op, mem_timeout
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state_o, illegal_op, mem_timeout
  );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags the last allowed cycle.
module multicycle_control_mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Wait counter: clear has priority so a fresh memory state always starts at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The count equals the number of wait cycles already spent, so the current
  // cycle is the TIMEOUT_CYCLES-th one when it reaches TIMEOUT_CYCLES-1.
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath with a memory ready
// handshake, a per-access timeout and sticky error flags.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       timeout_q;
  logic       in_mem_state;
  logic       timer_expired;
  logic       timer_inc;
  logic       timer_clr;
  logic       mem_abort;
  logic       decode_bad;

  logic       pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timer_inc    = in_mem_state && !bus.mem_ready;
  // mem_ready on the final allowed cycle still completes the access.
  assign mem_abort    = timer_inc && timer_expired;
  // A timeout in FETCH stays in FETCH, so it must restart the count explicitly.
  assign timer_clr    = (state_next != state) || mem_abort;

  multicycle_control_mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Opcode latch so later states do not depend on IR being stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= '0;
    end else if (state == S_DECODE) begin
      op_q <= bus.op;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (decode_bad) illegal_q <= 1'b1;
      if (mem_abort)  timeout_q <= 1'b1;
    end
  end

  // Next-state and control decode from the registered state.
  always_comb begin
    state_next = state;
    decode_bad = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = PCSRC_ALU;
    alu_op     = 4'b0000;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALUOP_ADD;
        case (bus.op)
          OP_LW, OP_SW:                      state_next = S_MEM_ADDR;
          OP_R:                              state_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_next = S_EXEC_I;
          OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
          OP_J:                              state_next = S_JUMP;
          default: begin
            decode_bad = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = (op_q == OP_SW) ? ALUOP_SW : ALUOP_LW;
        state_next = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready)  state_next = S_MEM_WB;
        else if (mem_abort) state_next = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready || mem_abort) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_R;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = imm_alu_op(op_q);
        state_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        if (op_q == OP_BNE) begin
          branch_ne = 1'b1;
          alu_op    = ALUOP_BNE;
        end else begin
          branch_eq = 1'b1;
          alu_op    = ALUOP_BEQ;
        end
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write enables are masked while reset is low so an aborted instruction
  // cannot commit anything on the resetting edge.
  assign bus.PCWrite     = pc_write  & reset;
  assign bus.BranchEQ    = branch_eq & reset;
  assign bus.BranchNE    = branch_ne & reset;
  assign bus.MemWrite    = mem_write & reset;
  assign bus.IRWrite     = ir_write  & reset;
  assign bus.RegWrite    = reg_write & reset;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = alu_op;
  assign bus.state_o     = state;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams with random memory
// wait profiles, checked cycle by cycle against a path-level reference model.
module tb_multicycle_control;

  localparam int TO = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  multicycle_control_if bus();

  multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit rdy;
    bit set_to;
    bit set_ill;
  } step_t;

  step_t      path[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         ill_m   = 1'b0;
  bit         to_m    = 1'b0;
  logic [5:0] cur_op;
  logic [5:0] legal_ops [10] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f,
                                 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Control outputs packed as {PCWrite,BranchEQ,BranchNE,IorD,MemRead,MemWrite,
  // IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp}.
  function automatic logic [18:0] dut_ctrl();
    return {bus.PCWrite, bus.BranchEQ, bus.BranchNE, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp};
  endfunction

  // Control table for each state as the datapath expects it.
  function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] iop, input bit rdy);
    logic pcw = 0, beq = 0, bne = 0, iord = 0, mrd = 0, mwr = 0;
    logic irw = 0, m2r = 0, rdst = 0, rw = 0, srca = 0;
    logic [1:0] srcb = 0, pcs = 0;
    logic [3:0] aop = 0;
    case (st)
      0:  begin mrd = 1; srcb = 2'd1; aop = 4'h1; irw = rdy; pcw = rdy; end
      1:  begin srcb = 2'd3; aop = 4'h1; end
      2:  begin srca = 1; srcb = 2'd2; aop = (iop == 6'h2b) ? 4'h5 : 4'h6; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin srca = 1; aop = 4'hf; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin
            srca = 1; srcb = 2'd2;
            aop = (iop == 6'h0c) ? 4'h3 : (iop == 6'h0d) ? 4'h2 : (iop == 6'h0f) ? 4'h4 : 4'h1;
          end
      9:  rw = 1;
      10: begin
            srca = 1; pcs = 2'd1;
            if (iop == 6'h05) begin bne = 1; aop = 4'h8; end
            else begin beq = 1; aop = 4'h7; end
          end
      11: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aop};
  endfunction

  function automatic void push(input int st, input bit rdy, input bit set_to = 1'b0);
    step_t s;
    s.st = st; s.rdy = rdy; s.set_to = set_to; s.set_ill = 1'b0;
    path.push_back(s);
  endfunction

  // One memory residence: wait_c idle cycles then ready, unless the wait
  // exceeds the timeout budget. Returns 1 when the access completed.
  function automatic bit add_mem(input int st, input int wait_c);
    if (wait_c >= TO) begin
      for (int i = 0; i < TO; i++) push(st, 1'b0, i == TO - 1);
      return 1'b0;
    end
    for (int i = 0; i < wait_c; i++) push(st, 1'b0);
    push(st, 1'b1);
    return 1'b1;
  endfunction

  // Expected state path of one instruction given its memory wait profile.
  function automatic void build(input logic [5:0] iop, input int fw, input int mw);
    int rem = fw;
    path.delete();
    while (!add_mem(0, rem)) rem -= TO;
    push(1, 1'($urandom));
    case (iop)
      6'h00:                      begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin push(8, 1'($urandom)); push(9, 1'($urandom)); end
      6'h23: begin
        push(2, 1'($urandom));
        if (add_mem(3, mw)) push(4, 1'($urandom));
      end
      6'h2b: begin
        push(2, 1'($urandom));
        void'(add_mem(5, mw));
      end
      6'h04, 6'h05: push(10, 1'($urandom));
      6'h02:        push(11, 1'($urandom));
      default:      path[path.size() - 1].set_ill = 1'b1;
    endcase
  endfunction

  task automatic run_path(input int limit);
    for (int i = 0; i < path.size() && i < limit; i++) begin
      @(negedge clk);
      reset         = 1'b1;
      bus.op        = (path[i].st == 1) ? cur_op : 6'($urandom);
      bus.mem_ready = path[i].rdy;
      #1;
      check($sformatf("state op=%0h", cur_op), 32'(bus.state_o), 32'(path[i].st));
      check($sformatf("ctrl op=%0h st=%0d", cur_op, path[i].st), 32'(dut_ctrl()),
            32'(exp_ctrl(path[i].st, cur_op, path[i].rdy)));
      check("illegal_op", 32'(bus.illegal_op), 32'(ill_m));
      check("mem_timeout", 32'(bus.mem_timeout), 32'(to_m));
      if (path[i].set_ill) ill_m = 1'b1;
      if (path[i].set_to)  to_m  = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] iop, input int fw, input int mw);
    cur_op = iop;
    build(iop, fw, mw);
    run_path(path.size());
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op        = 6'h00;
    @(negedge clk);
    #1;
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    check("rst_illegal", 32'(bus.illegal_op), 32'd0);
    check("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    ill_m = 1'b0;
    to_m  = 1'b0;
  endtask

  function automatic int rand_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return r % 3;
    if (r < 8) return TO - 1;
    return (r == 8) ? TO : TO + 5;
  endfunction

  initial begin
    bus.op        = 6'h00;
    bus.mem_ready = 1'b1;
    do_reset();

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h2b, 0, 1000);
    run_instr(6'h05, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(6'h08, 1, 0);
    run_instr(6'h0c, 0, 0);
    run_instr(6'h0d, 2, 0);
    run_instr(6'h0f, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h2b, 0, TO - 1);
    run_instr(6'h23, 0, TO);
    run_instr(6'h23, TO - 1, TO - 1);
    run_instr(6'h00, TO + 5, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] iop;
      if ($urandom_range(0, 9) < 8) iop = legal_ops[$urandom_range(0, 9)];
      else iop = 6'($urandom);
      run_instr(iop, ($urandom_range(0, 7) == 0) ? rand_wait() : int'($urandom_range(0, 2)),
                rand_wait());
    end

    // Reset asserted while a load sits in its register write-back cycle.
    cur_op = 6'h23;
    build(6'h23, 0, 0);
    run_path(4);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ready = 1'($urandom);
    bus.op        = 6'($urandom);
    #1;
    check("abort_state", 32'(bus.state_o), 32'd4);
    check("abort_regwrite", 32'(bus.RegWrite), 32'd0);
    do_reset();

    run_instr(6'h00, 0, 0);
    for (int n = 0; n < 20; n++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], int'($urandom_range(0, 2)), rand_wait());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multicycle MIPS datapath: one shared memory, one ALU, and the IR/A/B/ALUOut/MDR holding registers.
- Replaces the single-cycle opcode decoder. It keeps that decoder's 4-bit ALUOp encoding so the existing ALU control block is reused unchanged.
- Adds a memory ready handshake with a timeout, plus sticky error flags.

Parameters:
- TIMEOUT_CYCLES, 15, maximum cycles to wait for mem_ready in any memory state before aborting (1..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- op  in  6  opcode field IR[31:26]
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- BranchEQ  out  1  PC load if ALU zero
- BranchNE  out  1  PC load if ALU not zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- MemtoReg  out  1  RegFile write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  write register: 0 = rt, 1 = rd
- RegWrite  out  1  RegFile write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  4  code consumed by ALU control
- state_o  out  4  current state, for debug
- illegal_op  out  1  sticky: an unknown opcode was decoded
- mem_timeout  out  1  sticky: a memory wait expired

Behaviour:
- Opcodes: R = 00, ADDI = 08, ANDI = 0c, ORI = 0d, LUI = 0f, LW = 23, SW = 2b, BEQ = 04, BNE = 05, J = 02.
- ALUOp codes: R = 1111, ADDI/add = 0001, ORI = 0010, ANDI = 0011, LUI = 0100, SW = 0101, LW = 0110, BEQ = 0111, BNE = 1000.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11.
- Reset: while reset == 0 at a clock edge:
  - state <= FETCH; wait counter <= 0; op latch <= 0; illegal_op <= 0; mem_timeout <= 0.
  - All outputs are decoded from registered state, so after reset they take FETCH values.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 0001, PCSource = 00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready = 1, then next state is DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives ALUSrcA = 0, ALUSrcB = 11, ALUOp = 0001; the branch target goes into ALUOut.
  - Latches op.
  - Next state: LW/SW -> MEM_ADDR; R -> EXEC_R; ADDI/ANDI/ORI/LUI -> EXEC_I; BEQ/BNE -> BRANCH; J -> JUMP.
  - Any other opcode sets illegal_op and goes to FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 0110 (LW) or 0101 (SW). Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: IorD = 1, MemRead = 1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0, then FETCH.
- MEM_WR: IorD = 1, MemWrite = 1. Wait for mem_ready, then FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 1111, then R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0, then FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp from the latched opcode, then I_WB.
- I_WB: RegWrite = 1, RegDst = 0, then FETCH.
- BRANCH:
  - Drives ALUSrcA = 1, ALUSrcB = 00, PCSource = 01.
  - BEQ: BranchEQ = 1, ALUOp = 0111. BNE: BranchNE = 1, ALUOp = 1000.
  - Then FETCH.
- JUMP: PCWrite = 1, PCSource = 10, then FETCH.
- Instruction latency in cycles, with zero memory wait: R/I-type 4, LW 5, SW 4, branch/J 3. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while mem_ready = 0.
  - If it reaches TIMEOUT_CYCLES with mem_ready still 0: set mem_timeout and go to FETCH, with no IR, PC or Reg write and no further strobe.
  - If mem_ready arrives on that same cycle, mem_ready wins.
- Strobe timing: MemWrite is held high for the whole MEM_WR residence. Memory must commit the write only on the mem_ready cycle.
- Sticky flags are cleared only by reset.
- Reset asserted mid-instruction aborts immediately; no write enable is asserted on that edge.

Decomposition:
- Shared package/include holds:
  - opcode localparams;
  - ALUOp codes, shared with the single-cycle decoder and ALU control;
  - state encodings;
  - ALUSrcB and PCSource select codes.
- Optional sub-module mem_wait_timer: counter with clr, inc and expired outputs, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Reset low for 2 cycles, then high, with mem_ready = 1 -> state_o = 0, MemRead = 1 and IRWrite = 1 in the first cycle after release. Both flags are 0.
- op = 00, mem_ready = 1 -> states 0, 1, 6, 7, 0. ALUOp = 1111 in EXEC_R. RegDst = 1 and RegWrite = 1 for exactly 1 cycle.
- op = 23, mem_ready low for 3 cycles in MEM_RD -> the 5-state sequence stretches to 8 cycles. MemtoReg = 1 and RegWrite = 1 in state 4.
- op = 2b with mem_ready never asserted, TIMEOUT_CYCLES = 15 -> MemWrite high for 15 cycles, then mem_timeout = 1 and state_o = 0. No RegWrite at any point.
- op = 05 -> state 10 with BranchNE = 1, ALUOp = 1000, PCSource = 01. Then op = 02 -> state 11 with PCWrite = 1, PCSource = 10.
- op = 3f -> DECODE goes to FETCH and illegal_op = 1, which stays set across later valid instructions until reset. Reset during MEM_WB -> RegWrite = 0 on that edge.
